// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants
// and a 3-input majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int UART_OS_RATE    = 16;
  localparam int UART_SAMPLE_MID = 8;
  localparam int UART_DATA_BITS  = 8;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Host-side byte handshake and error flags of the oversampling UART receiver.
interface uart_rx_os16_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_accept;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_accept
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_accept
  );

endinterface

// File: rtl/uart_os_tick.sv
// Free-running oversample tick: one-clock pulse every OS_DIV system clocks.
module uart_os_tick #(
  parameter int OS_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = $clog2(OS_DIV);
  localparam logic [W-1:0] LAST = W'(OS_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN defined),
// majority vote of three mid-bit samples, valid/accept byte handoff.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int OS_DIV = 27
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_os16_if.master host
);

  localparam logic [3:0] SC_LAST = 4'(UART_OS_RATE - 1);
  localparam logic [3:0] SC_MID  = 4'(UART_SAMPLE_MID);
  localparam logic [3:0] SC_LO   = 4'(UART_SAMPLE_MID - 1);
  localparam logic [3:0] SC_HI   = 4'(UART_SAMPLE_MID + 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e state, state_n;

  logic       s1, rxs;
  logic       armed;
  logic       tick;
  logic [3:0] sc;
  logic [2:0] bitn;
  logic [7:0] shreg;
  logic       smp7, smp8, smp9;
  logic       par_bad;

  logic bit_end, stop_now, maj_bit, stop_bit;
  logic good, take;

  uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= rx;
      rxs <= s1;
    end
  end

  // A line held low across reset release must not look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else if (tick && rxs) begin
      armed <= 1'b1;
    end
  end

  assign bit_end  = tick && (sc == SC_LAST);
  assign stop_now = tick && (state == STOP) && (sc == SC_HI);
  assign maj_bit  = maj3(smp7, smp8, smp9);
  assign stop_bit = maj3(smp7, smp8, rxs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (tick && armed && !rxs) state_n = START;
      end
      START: begin
        if (bit_end) state_n = maj_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bitn == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (stop_now) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // sc holds the index of the next tick; the detect tick itself is sc 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc    <= '0;
      bitn  <= '0;
      shreg <= '0;
      smp7  <= 1'b0;
      smp8  <= 1'b0;
      smp9  <= 1'b0;
    end else begin
      if (tick) begin
        if (state == IDLE) begin
          sc <= (armed && !rxs) ? 4'd1 : 4'd0;
        end else if (stop_now) begin
          sc <= '0;
        end else begin
          sc <= sc + 4'd1;
        end
        if (sc == SC_LO) smp7 <= rxs;
        if (sc == SC_MID) smp8 <= rxs;
        if (sc == SC_HI) smp9 <= rxs;
      end
      if (state == IDLE) begin
        bitn <= '0;
      end else if (bit_end && (state == DATA)) begin
        shreg <= {maj_bit, shreg[7:1]};
        bitn  <= bitn + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad <= 1'b0;
    end else if (bit_end && (state == PARITY)) begin
      par_bad <= (maj_bit != ^shreg);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host.parity_err <= 1'b0;
    end else begin
      host.parity_err <= stop_now && par_bad;
    end
  end
`else
  assign par_bad         = 1'b0;
  assign host.parity_err = 1'b0;
`endif

  assign good = stop_now && stop_bit && !par_bad;
  assign take = host.rx_accept && host.rx_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host.rx_data   <= '0;
      host.rx_valid  <= 1'b0;
      host.overrun   <= 1'b0;
      host.frame_err <= 1'b0;
    end else begin
      host.frame_err <= stop_now && !stop_bit;
      if (good && (take || !host.rx_valid)) begin
        host.rx_data  <= shreg;
        host.rx_valid <= 1'b1;
      end else if (take) begin
        host.rx_valid <= 1'b0;
      end
      if (take) begin
        host.overrun <= 1'b0;
      end else if (good && host.rx_valid) begin
        host.overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed + randomized bench for uart_rx_os16 with OS_DIV=4 (64-clock bit).
`timescale 1ns/1ps
module tb_uart_rx_os16;

  localparam int OS  = 4;
  localparam int BIT = 16 * OS;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;

  always #5 clk = ~clk;

  uart_rx_os16_if hif ();

  uart_rx_os16 #(.OS_DIV(OS)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .host  (hif.master)
  );

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int fe_hi = 0, fe_rise = 0, pe_hi = 0, pe_rise = 0;
  int v_rise_cyc = 0;
  int last_start = 0;
  logic fe_d = 1'b0, pe_d = 1'b0, v_d = 1'b0;

  logic [7:0] m_data = 8'h00;
  bit m_valid = 1'b0;
  bit m_ovr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (hif.frame_err === 1'b1) fe_hi++;
    if (hif.frame_err === 1'b1 && fe_d !== 1'b1) fe_rise++;
    if (hif.parity_err === 1'b1) pe_hi++;
    if (hif.parity_err === 1'b1 && pe_d !== 1'b1) pe_rise++;
    if (hif.rx_valid === 1'b1 && v_d !== 1'b1) v_rise_cyc = cyc;
    fe_d = hif.frame_err;
    pe_d = hif.parity_err;
    v_d  = hif.rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".data"}, 32'(hif.rx_data), 32'(m_data));
    chk({tag, ".valid"}, 32'(hif.rx_valid), 32'(m_valid));
    chk({tag, ".ovr"}, 32'(hif.overrun), 32'(m_ovr));
  endtask

  // Frame-level model: a good frame delivers unless a byte is pending.
  task automatic send(input logic [7:0] d, input logic stop,
                      input logic par, input string tag);
    int fe0, fer0, pe0, per0;
    bit exp_fe, exp_pe;
    fe0 = fe_hi; fer0 = fe_rise; pe0 = pe_hi; per0 = pe_rise;
    last_start = cyc;
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (PAR) hold(par, BIT);
    hold(stop, BIT);
    exp_fe = !stop;
    exp_pe = PAR && (par != ^d);
    if (stop && !exp_pe) begin
      if (m_valid) m_ovr = 1'b1;
      else begin
        m_data  = d;
        m_valid = 1'b1;
      end
    end
    chk_outputs(tag);
    chk({tag, ".fe_cyc"}, 32'(fe_hi - fe0), 32'(exp_fe));
    chk({tag, ".fe_pulse"}, 32'(fe_rise - fer0), 32'(exp_fe));
    chk({tag, ".pe_cyc"}, 32'(pe_hi - pe0), 32'(exp_pe));
    chk({tag, ".pe_pulse"}, 32'(pe_rise - per0), 32'(exp_pe));
  endtask

  task automatic accept();
    hif.rx_accept = 1'b1;
    @(posedge clk);
    #1;
    hif.rx_accept = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  initial begin
    int fe0, pe0, lim;
    logic [7:0] d;
    logic stop, par;

    hif.rx_accept = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_outputs("reset");
    chk("reset.fe", 32'(hif.frame_err), 32'd0);
    chk("reset.pe", 32'(hif.parity_err), 32'd0);
    reset = 1'b1;
    hold(1'b1, 2 * BIT);

    // basic byte, latency and accept
    send(8'h66, 1'b1, ^8'h66, "t1");
    lim = 620 + (PAR ? BIT : 0);
    chk("t1.latency", 32'((v_rise_cyc > last_start) &&
                          (v_rise_cyc - last_start <= lim)), 32'd1);
    accept();
    chk("t1.accept_valid", 32'(hif.rx_valid), 32'd0);

    // start-bit glitch rejected
    fe0 = fe_hi; pe0 = pe_hi;
    hold(1'b0, 12);
    hold(1'b1, 100);
    chk_outputs("t2");
    chk("t2.fe", 32'(fe_hi - fe0), 32'd0);
    chk("t2.pe", 32'(pe_hi - pe0), 32'd0);

    // framing error
    send(8'hA5, 1'b0, ^8'hA5, "t3");
    hold(1'b1, 100);

    // back-to-back with overrun
    send(8'h11, 1'b1, ^8'h11, "t4a");
    send(8'h22, 1'b1, ^8'h22, "t4b");
    chk("t4.ovr_set", 32'(hif.overrun), 32'd1);
    accept();
    chk_outputs("t4.acc");

    // reset mid-frame, line held low afterwards
    fe0 = fe_hi; pe0 = pe_hi;
    hold(1'b0, BIT);
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    hold(1'b1, 20);
    reset = 1'b0;
    #1;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    chk_outputs("t5.in_reset");
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    hold(1'b0, 100);
    chk_outputs("t5.after");
    chk("t5.fe", 32'(fe_hi - fe0), 32'd0);
    chk("t5.pe", 32'(pe_hi - pe0), 32'd0);
    hold(1'b1, 2 * BIT);
    send(8'h3C, 1'b1, ^8'h3C, "t5.rx");
    accept();

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, "t6.bad");
    hold(1'b1, 20);
    send(8'h07, 1'b1, 1'b1, "t6.good");
    accept();
`endif

    // randomized frames, errors and accepts
    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^d) ^ (PAR && ($urandom_range(0, 3) == 0));
      send(d, stop, par, $sformatf("rnd%0d", k));
      if (!stop) hold(1'b1, 100);
      else hold(1'b1, $urandom_range(0, 10));
      if ($urandom_range(0, 1) == 1) begin
        accept();
        chk($sformatf("rnd%0d.acc", k), 32'(hif.rx_valid), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
